// File: rtl/lsu_mem_access_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, lane helpers.
// Misaligned splitting is enabled by defining LSU_MISALIGNED_SPLIT_EN.
package lsu_mem_access_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Encoding 3 is not a legal size and behaves as a word access.
  function automatic size_e decodeSize(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [2:0] byteCount(input size_e s);
    case (s)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [LANES-1:0] sizeMask(input size_e s);
    case (s)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Request/response port between execute and the LSU, and the LSU data-memory bus.
// Master drives the request side of each link; slave answers it.
interface lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_bus_if import lsu_mem_access_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_access_align.sv
// Lane steering for the LSU: per-beat byte enables and store data, plus
// reassembly and sign/zero extension of load data.
module lsu_align import lsu_mem_access_pkg::*; (
  input  logic        i_beat,
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic        i_split,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd0,
  input  logic [31:0] i_rd1,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shift;
  logic [7:0]  w_beWide;
  logic [63:0] w_dataWide;
  logic [63:0] w_rawWide;
  logic [31:0] w_raw;
  logic [31:0] w_rd1;

  // Shifting into a double-width window gives beat 0 in the low half and the
  // spill-over for beat 1 in the high half.
  assign w_shift    = {i_off, 3'b000};
  assign w_beWide   = {4'b0000, sizeMask(i_size)} << i_off;
  assign w_dataWide = {32'd0, i_wdata} << w_shift;
  assign o_be       = i_beat ? w_beWide[7:4] : w_beWide[3:0];
  assign o_wdata    = i_beat ? w_dataWide[63:32] : w_dataWide[31:0];

  assign w_rd1     = i_split ? i_rd1 : 32'd0;
  assign w_rawWide = {w_rd1, i_rd0} >> w_shift;
  assign w_raw     = w_rawWide[31:0];

  always_comb begin
    o_rdata = w_raw;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{~i_unsigned & w_raw[7]}}, w_raw[7:0]};
      SZ_HALF: o_rdata = {{16{~i_unsigned & w_raw[15]}}, w_raw[15:0]};
      default: o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Single-outstanding load/store unit driving a request/grant/response memory bus.
// Define LSU_MISALIGNED_SPLIT_EN to run misaligned accesses (two beats when crossing a word).
module lsu_mem_access import lsu_mem_access_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  lsu_req_if.slave req,
  lsu_bus_if.master mem
);

  state_e            r_state;
  state_e            w_nextState;
  logic              r_we;
  logic              r_unsigned;
  logic              r_err;
  logic              r_split;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  size_e             w_inSize;
  logic [1:0]        w_inOff;
  logic              w_inErr;
  logic              w_inSplit;
  logic              w_accept;
  logic              w_beat;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_laneData;
  logic [DATA_W-1:0] w_loadData;

  assign w_inSize = decodeSize(req.req_size);
  assign w_inOff  = req.req_addr[1:0];
  assign w_accept = (r_state == ST_IDLE) && req.req_valid;

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign w_inErr   = 1'b0;
  assign w_inSplit = ({1'b0, w_inOff} + byteCount(w_inSize)) > 3'd4;
`else
  logic w_inNatural;
  assign w_inNatural = (w_inSize == SZ_BYTE) ||
                       ((w_inSize == SZ_HALF) && !w_inOff[0]) ||
                       (w_inOff == 2'b00);
  assign w_inErr   = !w_inNatural;
  assign w_inSplit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (req.req_valid) w_nextState = w_inErr ? ST_RESP : ST_REQ0;
      ST_REQ0:  if (mem.mem_gnt) w_nextState = ST_WAIT0;
      ST_WAIT0: if (mem.mem_rvalid) w_nextState = r_split ? ST_REQ1 : ST_RESP;
      ST_REQ1:  if (mem.mem_gnt) w_nextState = ST_WAIT1;
      ST_WAIT1: if (mem.mem_rvalid) w_nextState = ST_RESP;
      ST_RESP:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Request fields are captured once so the bus sees stable values through grant stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_split    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd0      <= '0;
      r_rd1      <= '0;
    end else begin
      if (w_accept) begin
        r_we       <= req.req_we;
        r_unsigned <= req.req_unsigned;
        r_err      <= w_inErr;
        r_split    <= w_inSplit;
        r_size     <= w_inSize;
        r_addr     <= req.req_addr;
        r_wdata    <= req.req_wdata;
        r_rd0      <= '0;
        r_rd1      <= '0;
      end
      if ((r_state == ST_WAIT0) && mem.mem_rvalid) r_rd0 <= mem.mem_rdata;
      if ((r_state == ST_WAIT1) && mem.mem_rvalid) r_rd1 <= mem.mem_rdata;
    end
  end

  assign w_beat = (r_state == ST_REQ1) || (r_state == ST_WAIT1);

  lsu_align u_align (
    .i_beat     (w_beat),
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_split    (r_split),
    .i_wdata    (r_wdata),
    .i_rd0      (r_rd0),
    .i_rd1      (r_rd1),
    .o_be       (w_be),
    .o_wdata    (w_laneData),
    .o_rdata    (w_loadData)
  );

  assign mem.mem_req   = (r_state == ST_REQ0) || (r_state == ST_REQ1);
  assign mem.mem_we    = mem.mem_req && r_we;
  assign mem.mem_addr  = mem.mem_req ?
                         ({r_addr[ADDR_W-1:2], 2'b00} + (w_beat ? ADDR_W'(4) : ADDR_W'(0))) : '0;
  assign mem.mem_be    = mem.mem_req ? w_be : 4'b0000;
  assign mem.mem_wdata = (mem.mem_req && r_we) ? w_laneData : '0;

  assign req.req_ready  = (r_state == ST_IDLE);
  assign req.resp_valid = (r_state == ST_RESP);
  assign req.resp_err   = req.resp_valid && r_err;
  assign req.resp_rdata = (req.resp_valid && !r_we && !r_err) ? w_loadData : '0;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: aligned/sub-word loads and stores, grant stall,
// misaligned handling and reset while a bus transfer is outstanding.
module tb_lsu_mem_access;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   errorCount = 0;

  lsu_req_if reqIf ();
  lsu_bus_if busIf ();

  lsu_mem_access dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (reqIf),
    .mem   (busIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    reqIf.req_valid    = 1'b1;
    reqIf.req_we       = we;
    reqIf.req_size     = size;
    reqIf.req_unsigned = uns;
    reqIf.req_addr     = addr;
    reqIf.req_wdata    = wdata;
  endtask

  // One-beat access with immediate grant: accept, REQ0, WAIT0, RESP, back to IDLE.
  task automatic runSingle(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expAddr, input logic [3:0] expBe, input logic [31:0] expWdata,
                           input logic [31:0] rdata, input logic [31:0] expRdata);
    applyStimulus(we, size, uns, addr, wdata);
    checkOutput({tag, ".ready"}, 32'(reqIf.req_ready), 32'd1);
    tick();
    reqIf.req_valid = 1'b0;
    checkOutput({tag, ".memReq"}, 32'(busIf.mem_req), 32'd1);
    checkOutput({tag, ".memWe"}, 32'(busIf.mem_we), 32'(we));
    checkOutput({tag, ".memAddr"}, busIf.mem_addr, expAddr);
    checkOutput({tag, ".memBe"}, 32'(busIf.mem_be), 32'(expBe));
    if (we) checkOutput({tag, ".memWdata"}, busIf.mem_wdata, expWdata);
    busIf.mem_gnt = 1'b1;
    tick();
    busIf.mem_gnt = 1'b0;
    checkOutput({tag, ".waitNoReq"}, 32'(busIf.mem_req), 32'd0);
    checkOutput({tag, ".waitNoResp"}, 32'(reqIf.resp_valid), 32'd0);
    busIf.mem_rvalid = 1'b1;
    busIf.mem_rdata  = rdata;
    tick();
    busIf.mem_rvalid = 1'b0;
    checkOutput({tag, ".respValid"}, 32'(reqIf.resp_valid), 32'd1);
    checkOutput({tag, ".respRdata"}, reqIf.resp_rdata, expRdata);
    checkOutput({tag, ".respErr"}, 32'(reqIf.resp_err), 32'd0);
    tick();
    checkOutput({tag, ".respDone"}, 32'(reqIf.resp_valid), 32'd0);
    checkOutput({tag, ".readyAgain"}, 32'(reqIf.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    reqIf.req_valid    = 1'b0;
    reqIf.req_we       = 1'b0;
    reqIf.req_size     = 2'd0;
    reqIf.req_unsigned = 1'b0;
    reqIf.req_addr     = 32'd0;
    reqIf.req_wdata    = 32'd0;
    busIf.mem_gnt      = 1'b0;
    busIf.mem_rvalid   = 1'b0;
    busIf.mem_rdata    = 32'd0;
    #12;
    checkOutput("reset.ready", 32'(reqIf.req_ready), 32'd1);
    checkOutput("reset.memReq", 32'(busIf.mem_req), 32'd0);
    checkOutput("reset.respValid", 32'(reqIf.resp_valid), 32'd0);
    checkOutput("reset.respErr", 32'(reqIf.resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    runSingle("lw100", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'h100, 4'hF, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF);
    runSingle("lb103", 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 32'h100, 4'b1000, 32'd0, 32'h80123456, 32'hFFFFFF80);
    runSingle("lbu103", 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 32'h100, 4'b1000, 32'd0, 32'h80123456, 32'h00000080);
    runSingle("sh102", 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h100, 4'b1100, 32'hABCD0000, 32'h12345678, 32'd0);
    runSingle("lbu101", 1'b0, 2'd0, 1'b1, 32'h101, 32'd0, 32'h100, 4'b0010, 32'd0, 32'h1234F678, 32'h000000F6);
    runSingle("size3", 1'b0, 2'd3, 1'b0, 32'h104, 32'd0, 32'h104, 4'hF, 32'd0, 32'h0BADF00D, 32'h0BADF00D);
    runSingle("sb201", 1'b1, 2'd0, 1'b0, 32'h201, 32'h000000A5, 32'h200, 4'b0010, 32'h0000A500, 32'd0, 32'd0);

    // Grant stall: bus outputs held for three cycles, stray rvalid ignored.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344);
    tick();
    reqIf.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busIf.mem_rvalid = (i == 1);
      busIf.mem_rdata  = 32'hCAFEF00D;
      checkOutput("stall.memReq", 32'(busIf.mem_req), 32'd1);
      checkOutput("stall.memAddr", busIf.mem_addr, 32'h200);
      checkOutput("stall.memBe", 32'(busIf.mem_be), 32'hF);
      checkOutput("stall.memWdata", busIf.mem_wdata, 32'h11223344);
      checkOutput("stall.memWe", 32'(busIf.mem_we), 32'd1);
      checkOutput("stall.noResp", 32'(reqIf.resp_valid), 32'd0);
      tick();
    end
    busIf.mem_rvalid = 1'b0;
    checkOutput("stall.stillReq", 32'(busIf.mem_req), 32'd1);
    busIf.mem_gnt = 1'b1;
    tick();
    busIf.mem_gnt = 1'b0;
    checkOutput("stall.wait", 32'(busIf.mem_req), 32'd0);
    busIf.mem_rvalid = 1'b1;
    tick();
    busIf.mem_rvalid = 1'b0;
    checkOutput("stall.respValid", 32'(reqIf.resp_valid), 32'd1);
    checkOutput("stall.respRdata", reqIf.resp_rdata, 32'd0);
    tick();
    checkOutput("stall.ready", 32'(reqIf.req_ready), 32'd1);

`ifdef LSU_MISALIGNED_SPLIT_EN
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0FE, 32'd0);
    tick();
    reqIf.req_valid = 1'b0;
    checkOutput("mis.beat0Addr", busIf.mem_addr, 32'h0FC);
    checkOutput("mis.beat0Be", 32'(busIf.mem_be), 32'b1100);
    busIf.mem_gnt = 1'b1;
    tick();
    busIf.mem_gnt    = 1'b0;
    busIf.mem_rvalid = 1'b1;
    busIf.mem_rdata  = 32'h2211AAAA;
    tick();
    busIf.mem_rvalid = 1'b0;
    checkOutput("mis.beat1Req", 32'(busIf.mem_req), 32'd1);
    checkOutput("mis.beat1Addr", busIf.mem_addr, 32'h100);
    checkOutput("mis.beat1Be", 32'(busIf.mem_be), 32'b0011);
    busIf.mem_gnt = 1'b1;
    tick();
    busIf.mem_gnt    = 1'b0;
    busIf.mem_rvalid = 1'b1;
    busIf.mem_rdata  = 32'hBBBB4433;
    tick();
    busIf.mem_rvalid = 1'b0;
    checkOutput("mis.respValid", 32'(reqIf.resp_valid), 32'd1);
    checkOutput("mis.respRdata", reqIf.resp_rdata, 32'h44332211);
    checkOutput("mis.respErr", 32'(reqIf.resp_err), 32'd0);
    tick();
`else
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0FE, 32'd0);
    tick();
    reqIf.req_valid = 1'b0;
    checkOutput("mis.noReq", 32'(busIf.mem_req), 32'd0);
    checkOutput("mis.respValid", 32'(reqIf.resp_valid), 32'd1);
    checkOutput("mis.respErr", 32'(reqIf.resp_err), 32'd1);
    checkOutput("mis.respRdata", reqIf.resp_rdata, 32'd0);
    tick();
    checkOutput("mis.ready", 32'(reqIf.req_ready), 32'd1);
    checkOutput("mis.respDone", 32'(reqIf.resp_valid), 32'd0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h101, 32'd0);
    tick();
    reqIf.req_valid = 1'b0;
    checkOutput("misH.noReq", 32'(busIf.mem_req), 32'd0);
    checkOutput("misH.respErr", 32'(reqIf.resp_err), 32'd1);
    tick();
`endif

    // Reset while waiting for read data abandons the transfer immediately.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
    tick();
    reqIf.req_valid = 1'b0;
    busIf.mem_gnt   = 1'b1;
    tick();
    busIf.mem_gnt = 1'b0;
    checkOutput("rstWait.busy", 32'(reqIf.req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstWait.ready", 32'(reqIf.req_ready), 32'd1);
    checkOutput("rstWait.memReq", 32'(busIf.mem_req), 32'd0);
    checkOutput("rstWait.respValid", 32'(reqIf.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    runSingle("lh302", 1'b0, 2'd1, 1'b0, 32'h302, 32'd0, 32'h300, 4'b1100, 32'd0, 32'h80011234, 32'hFFFF8001);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
